// File: rtl/io_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// io_bus_arbiter_if
// Request/acknowledge port of one I/O bus master (CPU or auxiliary master).
//   req      master -> arbiter  transfer request, held until ack
//   write    master -> arbiter  1 = write, 0 = read
//   lock     master -> arbiter  keep the grant after this transfer
//   address  master -> arbiter  I/O address
//   wdata    master -> arbiter  write data
//   ack      arbiter -> master  one-cycle completion pulse
//   rdata    arbiter -> master  read data, valid while ack = 1, 0 otherwise
// Modports: master (drives the request side), slave (the arbiter's view).
// -----------------------------------------------------------------------------
interface io_bus_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              req;
   logic              write;
   logic              lock;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, write, lock, address, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, write, lock, address, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/io_bus_arbiter.sv
// -----------------------------------------------------------------------------
// io_bus_arbiter
// Shares the single-port I/O register block between the CPU and an auxiliary
// master (debug/serial loader). Round-robin arbitration with a req/ack
// handshake and an optional bus lock for atomic read-modify-write sequences.
// Every transfer is IDLE/DONE -> ACCESS (one cycle on the io bus) -> DONE
// (ack pulse). A locked master keeps the bus: DONE -> ACCESS directly.
//
// Ports
//   clock, reset_s2_n   system clock, asynchronous active-low reset
//   cpu_if, aux_if      master ports (io_bus_arbiter_if.slave)
//   io_address_o        address to the io block (0 when the bus is idle)
//   io_data_in_o        write data to the io block
//   io_write_enable_o   write strobe to the io block (ACCESS cycle only)
//   io_data_out_i       combinational read data from the io block
//   lock_timeout_o      one-cycle pulse on a forced lock release
//
// Build option
//   IO_ARB_LOCK_TIMEOUT_EN  when defined, a master may hold the lock for at
//   most MAX_LOCK consecutive transfers while the other master is waiting.
//   Without it the lock is honoured indefinitely and lock_timeout_o is 0.
// -----------------------------------------------------------------------------
module io_bus_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int MAX_LOCK = 16
) (
   input  logic              clock,
   input  logic              reset_s2_n,
   io_bus_arbiter_if.slave   cpu_if,
   io_bus_arbiter_if.slave   aux_if,
   output logic [ADDR_W-1:0] io_address_o,
   output logic [DATA_W-1:0] io_data_in_o,
   output logic              io_write_enable_o,
   input  logic [DATA_W-1:0] io_data_out_i,
   output logic              lock_timeout_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;
   typedef enum logic {GNT_CPU = 1'b0, GNT_AUX = 1'b1} grant_e;

   state_e            state_q;
   grant_e            sel_q;
   grant_e            last_grant_q;
   logic              lock_q;        // lock bit of the transfer just completed
   logic [ADDR_W-1:0] io_address_q;
   logic [DATA_W-1:0] io_data_in_q;
   logic              io_we_q;
   logic              cpu_ack_q;
   logic              aux_ack_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] aux_rdata_q;
   logic              force_rel;

   // Source master: the arbitration winner while idle, else the current owner.
   logic              src_aux;
   logic              src_req;
   logic              src_write;
   logic              src_lock;
   logic [ADDR_W-1:0] src_addr;
   logic [DATA_W-1:0] src_wdata;

   // NOTE: assign a default first in every always_comb so that no path leaves
   // the output unassigned; otherwise synthesis infers a latch.
   always_comb begin
      src_aux = (sel_q == GNT_AUX);
      if (state_q == ST_IDLE) begin
         if (cpu_if.req && aux_if.req) src_aux = (last_grant_q == GNT_CPU);
         else                          src_aux = aux_if.req;
      end
   end

   assign src_req   = src_aux ? aux_if.req     : cpu_if.req;
   assign src_write = src_aux ? aux_if.write   : cpu_if.write;
   assign src_lock  = src_aux ? aux_if.lock    : cpu_if.lock;
   assign src_addr  = src_aux ? aux_if.address : cpu_if.address;
   assign src_wdata = src_aux ? aux_if.wdata   : cpu_if.wdata;

`ifdef IO_ARB_LOCK_TIMEOUT_EN
   localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

   logic [CNT_W-1:0] lock_cnt_q;
   logic [CNT_W-1:0] lock_cnt_d;
   logic             timeout_q;
   logic             oth_req;

   // Saturates so a lock held with nobody waiting cannot wrap the counter.
   assign lock_cnt_d     = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
   assign oth_req        = src_aux ? cpu_if.req : aux_if.req;
   assign force_rel      = timeout_q;
   assign lock_timeout_o = timeout_q;
`else
   assign force_rel      = 1'b0;
   assign lock_timeout_o = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         state_q      <= ST_IDLE;
         sel_q        <= GNT_CPU;
         last_grant_q <= GNT_AUX;   // CPU wins the first tie
         lock_q       <= 1'b0;
         io_address_q <= '0;
         io_data_in_q <= '0;
         io_we_q      <= 1'b0;
         cpu_ack_q    <= 1'b0;
         aux_ack_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         aux_rdata_q  <= '0;
`ifdef IO_ARB_LOCK_TIMEOUT_EN
         lock_cnt_q   <= '0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
`ifdef IO_ARB_LOCK_TIMEOUT_EN
               lock_cnt_q <= '0;
`endif
               if (cpu_if.req || aux_if.req) begin
                  sel_q        <= src_aux ? GNT_AUX : GNT_CPU;
                  io_address_q <= src_addr;
                  io_data_in_q <= src_wdata;
                  io_we_q      <= src_write;
                  state_q      <= ST_ACCESS;
               end
            end

            ST_ACCESS: begin
               io_address_q <= '0;
               io_data_in_q <= '0;
               io_we_q      <= 1'b0;
               last_grant_q <= sel_q;
               lock_q       <= src_lock;
               if (sel_q == GNT_CPU) begin
                  cpu_ack_q   <= 1'b1;
                  cpu_rdata_q <= io_we_q ? '0 : io_data_out_i;
               end else begin
                  aux_ack_q   <= 1'b1;
                  aux_rdata_q <= io_we_q ? '0 : io_data_out_i;
               end
`ifdef IO_ARB_LOCK_TIMEOUT_EN
               if (src_lock) lock_cnt_q <= lock_cnt_d;
               // Decided here so the pulse lines up with the DONE cycle it releases.
               timeout_q <= src_lock && oth_req && (lock_cnt_d == CNT_MAX);
`endif
               state_q <= ST_DONE;
            end

            ST_DONE: begin
               cpu_ack_q   <= 1'b0;
               aux_ack_q   <= 1'b0;
               cpu_rdata_q <= '0;
               aux_rdata_q <= '0;
`ifdef IO_ARB_LOCK_TIMEOUT_EN
               timeout_q   <= 1'b0;
`endif
               // Owner keeps the bus without rearbitration while locked.
               if (src_req && lock_q && !force_rel) begin
                  io_address_q <= src_addr;
                  io_data_in_q <= src_wdata;
                  io_we_q      <= src_write;
                  state_q      <= ST_ACCESS;
               end else begin
                  state_q      <= ST_IDLE;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign io_address_o      = io_address_q;
   assign io_data_in_o      = io_data_in_q;
   assign io_write_enable_o = io_we_q;
   assign cpu_if.ack        = cpu_ack_q;
   assign cpu_if.rdata      = cpu_rdata_q;
   assign aux_if.ack        = aux_ack_q;
   assign aux_if.rdata      = aux_rdata_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_io_bus_arbiter
// Self-checking bench for io_bus_arbiter. The io block is modelled as nine
// registers (0x00-0x08). Each round, a transaction-level schedule predicts
// which master owns the bus, the cycle of every ack, read data and io bus
// activity; the DUT is then checked cycle by cycle against it.
// -----------------------------------------------------------------------------
module tb_io_bus_arbiter;

   localparam int MAX_LOCK = 4;

   logic       clock = 1'b0;
   logic       reset_s2_n;
   logic [7:0] io_address;
   logic [7:0] io_data_in;
   logic       io_we;
   logic [7:0] io_data_out;
   logic       lock_timeout;

   logic [1:0] m_req, m_write, m_lock, m_ack;
   logic [7:0] m_addr [2];
   logic [7:0] m_wdata[2];
   logic [7:0] m_rdata[2];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int ref_last = 1;   // last served master: 0 = CPU, 1 = AUX

   // Round description
   int         len    [2];
   logic [7:0] tr_addr[2][8];
   logic       tr_wr  [2][8];
   logic [7:0] tr_data[2][8];

   logic [7:0] env_mem[16];   // io block contents
   logic [7:0] ref_mem[16];   // expected contents

   io_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) cpu_bus ();
   io_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) aux_bus ();

   assign cpu_bus.req     = m_req[0];
   assign cpu_bus.write   = m_write[0];
   assign cpu_bus.lock    = m_lock[0];
   assign cpu_bus.address = m_addr[0];
   assign cpu_bus.wdata   = m_wdata[0];
   assign aux_bus.req     = m_req[1];
   assign aux_bus.write   = m_write[1];
   assign aux_bus.lock    = m_lock[1];
   assign aux_bus.address = m_addr[1];
   assign aux_bus.wdata   = m_wdata[1];
   assign m_ack[0]        = cpu_bus.ack;
   assign m_ack[1]        = aux_bus.ack;
   assign m_rdata[0]      = cpu_bus.rdata;
   assign m_rdata[1]      = aux_bus.rdata;

   io_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_LOCK(MAX_LOCK)) dut (
      .clock             (clock),
      .reset_s2_n        (reset_s2_n),
      .cpu_if            (cpu_bus),
      .aux_if            (aux_bus),
      .io_address_o      (io_address),
      .io_data_in_o      (io_data_in),
      .io_write_enable_o (io_we),
      .io_data_out_i     (io_data_out),
      .lock_timeout_o    (lock_timeout)
   );

   always #10 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // io block: registers 0x00-0x08, reads 0 and ignores writes elsewhere
   assign io_data_out = (io_address <= 8'h08) ? env_mem[io_address[3:0]] : 8'h00;
   always @(posedge clock) begin
      if (io_we && io_address <= 8'h08) env_mem[io_address[3:0]] <= io_data_in;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_tr(input int m, input int k, input logic [7:0] a, input logic w,
                         input logic [7:0] d);
      tr_addr[m][k] = a;
      tr_wr[m][k]   = w;
      tr_data[m][k] = d;
   endtask

   task automatic present(input int m, input int k);
      m_req[m]   = 1'b1;
      m_write[m] = tr_wr[m][k];
      m_lock[m]  = (k < len[m] - 1);
      m_addr[m]  = tr_addr[m][k];
      m_wdata[m] = tr_data[m][k];
   endtask

   task automatic release_master(input int m);
      m_req[m]   = 1'b0;
      m_write[m] = 1'b0;
      m_lock[m]  = 1'b0;
   endtask

   // Called on a negedge with the arbiter idle.
   task automatic run_round(input string name);
      int         c0, t, owner, cnt, end_c, k;
      int         q[2], k_chk[2], k_drv[2];
      int         exp_ack[2][8];
      logic [7:0] exp_rd[2][8];
      int         tmo[$];
      logic       lk, hit, exp_we, exp_tmo;
      logic [7:0] exp_addr, exp_wd, a;

      // Transaction-level schedule: a transfer occupies two cycles; a locked
      // owner continues directly, otherwise one idle cycle precedes the next
      // grant, which goes round-robin when both masters are waiting.
      c0 = cyc;
      t  = c0;
      q[0] = 0;
      q[1] = 0;
      while (q[0] < len[0] || q[1] < len[1]) begin
         if (q[0] < len[0] && q[1] < len[1]) owner = 1 - ref_last;
         else                                owner = (q[0] < len[0]) ? 0 : 1;
         cnt = 0;
         while (1) begin
            k = q[owner];
            t += 2;
            exp_ack[owner][k] = t;
            a = tr_addr[owner][k];
            if (tr_wr[owner][k]) begin
               exp_rd[owner][k] = 8'h00;
               if (a <= 8'h08) ref_mem[a[3:0]] = tr_data[owner][k];
            end else begin
               exp_rd[owner][k] = (a <= 8'h08) ? ref_mem[a[3:0]] : 8'h00;
            end
            q[owner]++;
            cnt++;
            ref_last = owner;
            lk = (k < len[owner] - 1);
`ifdef IO_ARB_LOCK_TIMEOUT_EN
            if (lk && q[1-owner] < len[1-owner] && cnt == MAX_LOCK) begin
               tmo.push_back(t);
               break;
            end
`endif
            if (!lk) break;
         end
         t += 1;
      end
      end_c = t + 1;

      k_chk[0] = 0; k_chk[1] = 0;
      k_drv[0] = 0; k_drv[1] = 0;
      for (int c = c0; c <= end_c; c++) begin
         for (int m = 0; m < 2; m++) begin
            hit = 1'b0;
            if (k_chk[m] < len[m]) hit = (exp_ack[m][k_chk[m]] == c);
            check($sformatf("%s_ack%0d_c%0d", name, m, c - c0), m_ack[m], hit);
            check($sformatf("%s_rdata%0d_c%0d", name, m, c - c0), m_rdata[m],
                  hit ? exp_rd[m][k_chk[m]] : 8'h00);
            if (hit) k_chk[m]++;
         end
         exp_we = 1'b0; exp_addr = 8'h00; exp_wd = 8'h00; hit = 1'b0;
         for (int m = 0; m < 2; m++) begin
            if (k_chk[m] < len[m] && exp_ack[m][k_chk[m]] == c + 1) begin
               hit      = 1'b1;
               exp_we   = tr_wr[m][k_chk[m]];
               exp_addr = tr_addr[m][k_chk[m]];
               exp_wd   = tr_data[m][k_chk[m]];
            end
         end
         check($sformatf("%s_we_c%0d", name, c - c0), io_we, exp_we);
         if (hit) check($sformatf("%s_addr_c%0d", name, c - c0), io_address, exp_addr);
         if (hit && exp_we) check($sformatf("%s_wdata_c%0d", name, c - c0), io_data_in, exp_wd);
         exp_tmo = 1'b0;
         foreach (tmo[i]) if (tmo[i] == c) exp_tmo = 1'b1;
         check($sformatf("%s_tmo_c%0d", name, c - c0), lock_timeout, exp_tmo);

         // Master agents react to the DUT's ack like real masters would.
         for (int m = 0; m < 2; m++) begin
            if (c == c0) begin
               if (len[m] > 0) present(m, 0);
            end else if (m_ack[m] && k_drv[m] < len[m]) begin
               k_drv[m]++;
               if (k_drv[m] < len[m]) present(m, k_drv[m]);
               else                   release_master(m);
            end
         end
         @(negedge clock);
      end
      for (int m = 0; m < 2; m++) begin
         check($sformatf("%s_nack%0d", name, m), k_drv[m], len[m]);
         release_master(m);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, "_cpu_ack"}, m_ack[0], 1'b0);
      check({name, "_aux_ack"}, m_ack[1], 1'b0);
      check({name, "_cpu_rdata"}, m_rdata[0], 8'h00);
      check({name, "_aux_rdata"}, m_rdata[1], 8'h00);
      check({name, "_io_addr"}, io_address, 8'h00);
      check({name, "_io_data_in"}, io_data_in, 8'h00);
      check({name, "_io_we"}, io_we, 1'b0);
      check({name, "_lock_timeout"}, lock_timeout, 1'b0);
   endtask

   initial begin
      reset_s2_n = 1'b0;
      for (int m = 0; m < 2; m++) begin
         release_master(m);
         m_addr[m]  = 8'h00;
         m_wdata[m] = 8'h00;
      end
      for (int i = 0; i < 16; i++) begin
         env_mem[i] = 8'(i * 17);
         ref_mem[i] = 8'(i * 17);
      end
      env_mem[2] = 8'hA5;
      ref_mem[2] = 8'hA5;

      // 1: reset state, then a single CPU write
      #15;
      check_outputs_zero("rst");
      @(negedge clock);
      reset_s2_n = 1'b1;
      @(negedge clock);
      check_outputs_zero("idle");
      len[0] = 1; len[1] = 0;
      set_tr(0, 0, 8'h01, 1'b1, 8'hFF);
      run_round("t1");

      // 2: AUX read of register 2
      len[0] = 0; len[1] = 1;
      set_tr(1, 0, 8'h02, 1'b0, 8'h00);
      run_round("t2");

      // 3: simultaneous requests, twice
      for (int r = 0; r < 2; r++) begin
         len[0] = 1; len[1] = 1;
         set_tr(0, 0, 8'h04, 1'b1, 8'h3C);
         set_tr(1, 0, 8'h04, 1'b0, 8'h00);
         run_round($sformatf("t3_%0d", r));
      end

      // 4: locked CPU stream of three writes with AUX waiting
      len[0] = 3; len[1] = 1;
      for (int k = 0; k < 3; k++) set_tr(0, k, 8'(k), 1'b1, 8'(8'h10 + k));
      set_tr(1, 0, 8'h01, 1'b0, 8'h00);
      run_round("t4");

      // 5: reset asserted during the ACCESS cycle of a CPU write
      len[0] = 1; len[1] = 0;
      set_tr(0, 0, 8'h03, 1'b1, 8'h5A);
      present(0, 0);
      @(posedge clock);
      #2;
      check("t5_we_access", io_we, 1'b1);
      reset_s2_n = 1'b0;
      #1;
      check("t5_we_reset", io_we, 1'b0);
      check("t5_ack_reset", m_ack[0], 1'b0);
      @(negedge clock);
      release_master(0);
      reset_s2_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check($sformatf("t5_no_ack_%0d", i), m_ack[0], 1'b0);
      end
      check("t5_no_commit", env_mem[3], ref_mem[3]);
      ref_last = 1;
      len[0] = 0; len[1] = 1;
      set_tr(1, 0, 8'h03, 1'b0, 8'h00);
      run_round("t5_after");

      // 6: long locked CPU stream against a waiting AUX
      len[0] = 6; len[1] = 1;
      for (int k = 0; k < 6; k++) set_tr(0, k, 8'(k + 2), 1'b1, 8'(8'hC0 + k));
      set_tr(1, 0, 8'h05, 1'b0, 8'h00);
      run_round("t6");

      // Randomized rounds
      for (int r = 0; r < 40; r++) begin
         int mode;
         mode   = int'($urandom_range(0, 2));
         len[0] = (mode != 1) ? int'($urandom_range(1, 3)) : 0;
         len[1] = (mode != 0) ? int'($urandom_range(1, 3)) : 0;
         for (int m = 0; m < 2; m++)
            for (int k = 0; k < 3; k++)
               set_tr(m, k, 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)));
         run_round($sformatf("rnd%0d", r));
      end

      for (int i = 0; i < 9; i++) check($sformatf("mem%0d", i), env_mem[i], ref_mem[i]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
